module_display_scan: RTL and testbench

Time-multiplexed scan controller for the N-digit common-anode 7-segment display on the board. It shares one hex-to-segment decoder among all digits: it latches a packed hex value, steps through the digits at a programmable dwell rate, and drives the active-low anode enables and segment lines. A blanking gap between digits prevents ghosting. It sits between the datapath result registers and the board display pins.

---
 rtl/display_pkg.sv | 27 ++
 rtl/module_7segmentos.sv | 34 +++
 rtl/module_display_scan.sv | 154 +++++++++++++++
 tb/tb_module_display_scan.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg
// Shared types and constants for the 7-segment scan controller.
//   scan_state_e  : BLANK (anti-ghosting gap) / DRIVE (digit lit)
//   SEG_OFF       : all segments dark (active-low lines)
//   anodes_off()  : all digit enables inactive (active-low), 32 bits wide
//   anode_select(): active-low one-hot enable for a single digit, 32 bits wide
package display_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam int         MAX_DIGITS = 32;

  // Every anode released; callers truncate to their digit count.
  function automatic logic [MAX_DIGITS-1:0] anodes_off();
    return '1;
  endfunction

  // Only the selected anode pulled low; callers truncate to their digit count.
  function automatic logic [MAX_DIGITS-1:0] anode_select(input int unsigned idx);
    return ~(32'd1 << idx);
  endfunction

endpackage

// File: rtl/module_7segmentos.sv
// module_7segmentos
// Hex-to-7-segment decoder for a common-anode display.
//   hex_i : 4-bit hex digit
//   seg_o : segments {a,b,c,d,e,f,g}, a in bit 6, active-low
module module_7segmentos (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Pure lookup; a lit segment is driven to 0.
  always_comb begin
    seg_o = 7'h7F;
    case (hex_i)
      4'h0: seg_o = 7'b0000001;
      4'h1: seg_o = 7'b1001111;
      4'h2: seg_o = 7'b0010010;
      4'h3: seg_o = 7'b0000110;
      4'h4: seg_o = 7'b1001100;
      4'h5: seg_o = 7'b0100100;
      4'h6: seg_o = 7'b0100000;
      4'h7: seg_o = 7'b0001111;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0000100;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b1100000;
      4'hC: seg_o = 7'b0110001;
      4'hD: seg_o = 7'b1000010;
      4'hE: seg_o = 7'b0110000;
      4'hF: seg_o = 7'b0111000;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/module_display_scan.sv
// module_display_scan
// Time-multiplexed scan controller for an N-digit common-anode 7-segment
// display sharing a single decoder.
//   clk_i        : system clock, rising edge
//   rst_i        : synchronous active-high reset
//   enable_i     : scan enable; low forces the display dark and restarts the scan
//   load_i       : one-cycle strobe capturing value_i
//   value_i      : packed hex digits, nibble 0 is the rightmost digit
//   anodes_o     : digit enables, active-low
//   display_o    : segments {a..g}, active-low
//   digit_idx_o  : digit currently in its slot
//   frame_done_o : pulse in the last cycle of the last digit's slot
// Build option: define LEADING_ZERO_BLANK_EN to darken leading zero digits
// (digit 0 is always shown).
module module_display_scan
  import display_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        enable_i,
  input  logic                        load_i,
  input  logic [4*N_DIGITS-1:0]       value_i,
  output logic [N_DIGITS-1:0]         anodes_o,
  output logic [6:0]                  display_o,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx_o,
  output logic                        frame_done_o
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam scan_state_e      IDLE_STATE = scan_state_e'((BLANK_CYCLES > 0) ? BLANK : DRIVE);
  localparam logic [N_DIGITS-1:0] ANODES_OFF_N = N_DIGITS'(anodes_off());

  logic [4*N_DIGITS-1:0] pending_q, pending_d;
  logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  scan_state_e           state_q, state_d;
  logic [N_DIGITS-1:0]   anodes_q, anodes_d;
  logic [6:0]            display_q, display_d;
  logic [IDX_W-1:0]      digitIdx_q, digitIdx_d;
  logic                  frameDone_q, frameDone_d;

  logic [3:0] nibble;
  logic [6:0] segDecoded;
  logic       slotEnd;
  logic       frameEnd;
  logic       drive;
  logic       lzDark;

  // The one shared decoder always looks at the digit whose slot is running.
  assign nibble = shadow_q[{idx_q, 2'b00} +: 4];

  module_7segmentos u_decoder (
    .hex_i (nibble),
    .seg_o (segDecoded)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] upperNonZero;

  // upperNonZero[d] is set when any nibble from d up to the leftmost digit
  // is non-zero; a digit above 0 without it is a leading zero.
  always_comb begin
    upperNonZero = '0;
    upperNonZero[N_DIGITS-1] = |shadow_q[4*(N_DIGITS-1) +: 4];
    for (int d = N_DIGITS - 2; d >= 0; d--) begin
      upperNonZero[d] = upperNonZero[d+1] | (|shadow_q[4*d +: 4]);
    end
    lzDark = (idx_q != '0) && !upperNonZero[idx_q];
  end
`else
  assign lzDark = 1'b0;
`endif

  // Next-state logic. cnt/idx/state describe the cycle about to be shown,
  // and the output registers are loaded from them at the same edge, so the
  // pins follow the counters without extra latency. The shadow only changes
  // at a frame boundary or while the scan is held off, so a frame never
  // mixes old and new digits; a load landing on the boundary bypasses the
  // pending register so it is not a frame late.
  always_comb begin
    slotEnd  = (cnt_q == CNT_LAST);
    frameEnd = enable_i && slotEnd && (idx_q == IDX_LAST);

    pending_d = load_i ? value_i : pending_q;
    shadow_d  = shadow_q;
    if (!enable_i || frameEnd) begin
      shadow_d = load_i ? value_i : pending_q;
    end

    cnt_d   = cnt_q;
    idx_d   = idx_q;
    state_d = state_q;
    if (!enable_i) begin
      cnt_d   = '0;
      idx_d   = '0;
      state_d = IDLE_STATE;
    end else if (slotEnd) begin
      cnt_d   = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      state_d = IDLE_STATE;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      if (state_q == BLANK && cnt_q == BLANK_LAST) begin
        state_d = DRIVE;
      end
    end

    drive       = enable_i && (state_q == DRIVE) && !lzDark;
    anodes_d    = drive ? N_DIGITS'(anode_select(32'(idx_q))) : ANODES_OFF_N;
    display_d   = drive ? segDecoded : SEG_OFF;
    digitIdx_d  = enable_i ? idx_q : '0;
    frameDone_d = frameEnd;
  end

  // State and output registers; reset drops any pending load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q   <= '0;
      shadow_q    <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      state_q     <= IDLE_STATE;
      anodes_q    <= ANODES_OFF_N;
      display_q   <= SEG_OFF;
      digitIdx_q  <= '0;
      frameDone_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      shadow_q    <= shadow_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      state_q     <= state_d;
      anodes_q    <= anodes_d;
      display_q   <= display_d;
      digitIdx_q  <= digitIdx_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign anodes_o     = anodes_q;
  assign display_o    = display_q;
  assign digit_idx_o  = digitIdx_q;
  assign frame_done_o = frameDone_q;

endmodule

// File: tb/tb_module_display_scan.sv
// tb_module_display_scan
// Self-checking bench for module_display_scan with N_DIGITS=4,
// REFRESH_DIV=8, BLANK_CYCLES=2: a table of directed vectors plus a
// randomized run, both scored against a cycle-number based reference model.
module tb_module_display_scan;

  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  anodes;
  logic [6:0]  display;
  logic [1:0]  digitIdx;
  logic        frameDone;

  int compared   = 0;
  int mismatched = 0;
  int modelFails = 0;

  typedef struct {
    bit          rst;
    bit          en;
    bit          load;
    logic [15:0] value;
    int          cycles;
    logic [3:0]  anodes;
    logic [6:0]  display;
    logic [1:0]  idx;
    bit          fd;
    bit          lzDark;
    string       name;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  module_display_scan #(
    .N_DIGITS     (N),
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .load_i       (load),
    .value_i      (value),
    .anodes_o     (anodes),
    .display_o    (display),
    .digit_idx_o  (digitIdx),
    .frame_done_o (frameDone)
  );

  // Segment patterns {a..g}, active-low, as wired on the board.
  function automatic logic [6:0] segOf(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  // Reference model: counts enabled cycles since the scan (re)started and
  // derives the digit and slot offset arithmetically from that count.
  bit          modelValid = 1'b0;
  int          runCycle;
  int          mDigit;
  int          mOffset;
  bit          mLit;
  logic [15:0] pendingM;
  logic [15:0] shadowM;
  logic [3:0]  expAnodes;
  logic [6:0]  expDisplay;
  logic [1:0]  expIdx;
  logic        expFd;

  always @(posedge clk) begin
    if (rst) begin
      modelValid = 1'b1;
      runCycle   = 0;
      pendingM   = 16'h0;
      shadowM    = 16'h0;
      expAnodes  = 4'hF;
      expDisplay = 7'h7F;
      expIdx     = 2'd0;
      expFd      = 1'b0;
    end else if (!enable) begin
      runCycle   = 0;
      if (load) pendingM = value;
      shadowM    = pendingM;
      expAnodes  = 4'hF;
      expDisplay = 7'h7F;
      expIdx     = 2'd0;
      expFd      = 1'b0;
    end else begin
      mDigit  = (runCycle / R) % N;
      mOffset = runCycle % R;
      mLit    = (mOffset >= B);
`ifdef LEADING_ZERO_BLANK_EN
      if (mDigit > 0 && (shadowM >> (4 * mDigit)) == 16'h0) mLit = 1'b0;
`endif
      expAnodes  = mLit ? ~(4'b0001 << mDigit) : 4'hF;
      expDisplay = mLit ? segOf(shadowM[4*mDigit +: 4]) : 7'h7F;
      expIdx     = 2'(mDigit);
      expFd      = (mOffset == R - 1) && (mDigit == N - 1);
      if (load) pendingM = value;
      if (expFd) shadowM = pendingM;
      runCycle++;
    end
    #1;
    if (modelValid) begin
      compared++;
      if ({anodes, display, digitIdx, frameDone} !== {expAnodes, expDisplay, expIdx, expFd}) begin
        mismatched++;
        modelFails++;
        if (modelFails <= 20)
          $display("[TB] FAIL model t=%0t: got an=%b seg=%b idx=%0d fd=%b, want an=%b seg=%b idx=%0d fd=%b",
                   $time, anodes, display, digitIdx, frameDone, expAnodes, expDisplay, expIdx, expFd);
      end
    end
  end

  // Drive one vector's inputs from a negedge for the given number of edges;
  // the load strobe is only held for the first edge.
  task automatic applyStimulus(input vec_t v);
    rst    = v.rst;
    enable = v.en;
    load   = v.load;
    value  = v.value;
    for (int i = 0; i < v.cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      load = 1'b0;
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] a, input logic [6:0] d,
                             input logic [1:0] idx, input logic fd);
    compared++;
    if ({anodes, display, digitIdx, frameDone} !== {a, d, idx, fd}) begin
      mismatched++;
      $display("[TB] FAIL %s: got an=%b seg=%b idx=%0d fd=%b, want an=%b seg=%b idx=%0d fd=%b",
               name, anodes, display, digitIdx, frameDone, a, d, idx, fd);
    end
  endtask

  function automatic logic [15:0] randValue();
    logic [15:0] v;
    for (int k = 0; k < 4; k++)
      v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    load   = 1'b0;
    value  = 16'h0;

    vecs.push_back('{1, 1, 0, 16'h0000,  3, 4'hF,    7'h7F,      2'd0, 0, 0, "reset_hold"});
    vecs.push_back('{0, 1, 0, 16'h0000,  1, 4'hF,    7'h7F,      2'd0, 0, 0, "cyc0_dark"});
    vecs.push_back('{0, 1, 0, 16'h0000,  1, 4'hF,    7'h7F,      2'd0, 0, 0, "cyc1_dark"});
    vecs.push_back('{0, 1, 0, 16'h0000,  1, 4'b1110, 7'b0000001, 2'd0, 0, 0, "cyc2_digit0"});
    vecs.push_back('{0, 1, 1, 16'h12AF,  1, 4'b1110, 7'b0000001, 2'd0, 0, 0, "load_no_tear"});
    vecs.push_back('{0, 1, 0, 16'h0000, 28, 4'b0111, 7'b0000001, 2'd3, 1, 1, "frame0_done"});
    vecs.push_back('{0, 1, 0, 16'h0000,  1, 4'hF,    7'h7F,      2'd0, 0, 0, "frame1_blank"});
    vecs.push_back('{0, 1, 0, 16'h0000,  2, 4'b1110, 7'b0111000, 2'd0, 0, 0, "digit0_F"});
    vecs.push_back('{0, 1, 0, 16'h0000, 24, 4'b0111, 7'b1001111, 2'd3, 0, 0, "digit3_1"});
    vecs.push_back('{0, 1, 0, 16'h0000,  5, 4'b0111, 7'b1001111, 2'd3, 1, 0, "frame1_done"});
    vecs.push_back('{0, 1, 1, 16'h3333,  1, 4'hF,    7'h7F,      2'd0, 0, 0, "load3333"});
    vecs.push_back('{0, 1, 0, 16'h0000, 19, 4'b1011, 7'b0010010, 2'd2, 0, 0, "digit2_2"});
    vecs.push_back('{0, 1, 0, 16'h0000, 11, 4'b0111, 7'b1001111, 2'd3, 0, 0, "pre_boundary"});
    vecs.push_back('{0, 1, 1, 16'h4444,  1, 4'b0111, 7'b1001111, 2'd3, 1, 0, "boundary_load"});
    vecs.push_back('{0, 1, 0, 16'h0000,  3, 4'b1110, 7'b1001100, 2'd0, 0, 0, "bypass_digit0"});
    vecs.push_back('{0, 1, 0, 16'h0000, 24, 4'b0111, 7'b1001100, 2'd3, 0, 0, "bypass_digit3"});
    vecs.push_back('{0, 1, 0, 16'h0000, 24, 4'b1011, 7'b1001100, 2'd2, 0, 0, "digit2_drive"});
    vecs.push_back('{0, 0, 0, 16'h0000,  1, 4'hF,    7'h7F,      2'd0, 0, 0, "disable_now"});
    vecs.push_back('{0, 0, 1, 16'h7777,  4, 4'hF,    7'h7F,      2'd0, 0, 0, "disable_load"});
    vecs.push_back('{0, 1, 0, 16'h0000,  1, 4'hF,    7'h7F,      2'd0, 0, 0, "reenable_c0"});
    vecs.push_back('{0, 1, 0, 16'h0000,  2, 4'b1110, 7'b0001111, 2'd0, 0, 0, "reenable_c2"});
    vecs.push_back('{0, 1, 0, 16'h0000,  8, 4'b1101, 7'b0001111, 2'd1, 0, 0, "digit1_drive"});
    vecs.push_back('{1, 1, 1, 16'h5555,  1, 4'hF,    7'h7F,      2'd0, 0, 0, "midframe_rst"});
    vecs.push_back('{0, 1, 0, 16'h0000,  3, 4'b1110, 7'b0000001, 2'd0, 0, 0, "post_rst_c2"});
    vecs.push_back('{0, 1, 0, 16'h0000, 30, 4'hF,    7'h7F,      2'd0, 0, 0, "post_rst_c32"});
    vecs.push_back('{0, 1, 0, 16'h0000,  2, 4'b1110, 7'b0000001, 2'd0, 0, 0, "load_lost"});
`ifdef LEADING_ZERO_BLANK_EN
    vecs.push_back('{0, 1, 1, 16'h0050,  1, 4'b1110, 7'b0000001, 2'd0, 0, 0, "lz_load"});
    vecs.push_back('{0, 1, 0, 16'h0000, 39, 4'b1101, 7'b0100100, 2'd1, 0, 0, "lz_digit1_5"});
    vecs.push_back('{0, 1, 0, 16'h0000,  8, 4'hF,    7'h7F,      2'd2, 0, 0, "lz_digit2_dark"});
    vecs.push_back('{0, 1, 0, 16'h0000,  8, 4'hF,    7'h7F,      2'd3, 0, 0, "lz_digit3_dark"});
    vecs.push_back('{0, 1, 1, 16'h0000,  1, 4'hF,    7'h7F,      2'd3, 0, 0, "lz_load_zero"});
    vecs.push_back('{0, 1, 0, 16'h0000, 15, 4'hF,    7'h7F,      2'd1, 0, 0, "lz_zero_digit1"});
    vecs.push_back('{0, 1, 0, 16'h0000, 24, 4'b1110, 7'b0000001, 2'd0, 0, 0, "lz_zero_digit0"});
`endif

    @(negedge clk);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
`ifdef LEADING_ZERO_BLANK_EN
      if (vecs[i].lzDark)
        checkOutput(vecs[i].name, 4'hF, 7'h7F, vecs[i].idx, vecs[i].fd);
      else
        checkOutput(vecs[i].name, vecs[i].anodes, vecs[i].display, vecs[i].idx, vecs[i].fd);
`else
      checkOutput(vecs[i].name, vecs[i].anodes, vecs[i].display, vecs[i].idx, vecs[i].fd);
`endif
    end

    $display("[TB] directed vectors applied, starting random run");
    for (int i = 0; i < 1200; i++) begin
      rst    = ($urandom_range(0, 249) == 0);
      enable = ($urandom_range(0, 59) != 0);
      load   = enable && ($urandom_range(0, 14) == 0);
      value  = randValue();
      @(posedge clk);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
